// File: rtl/sig_meter_pkg.sv
// sig_meter_pkg: shared types and helpers for the multi-channel signal meter.
//   field_e    read-port field select (freq, duty, high width, low width)
//   sat_add    saturating add, saturation point 2^cw-1
//   cnt_trail  run length from bit 0 upward of bits equal to val
//   cnt_lead   run length from bit wid-1 downward of bits equal to val
//   edge_count transitions in a word, chained from the previous sample
// Helpers work on MAXW-bit operands; callers pass the real width, so any
// W and CW up to MAXW are supported.
package sig_meter_pkg;

  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    F_FREQ = 2'd0,
    F_DUTY = 2'd1,
    F_T1   = 2'd2,
    F_T0   = 2'd3
  } field_e;

  function automatic logic [MAXW-1:0] sat_add(input logic [MAXW-1:0] a,
                                              input logic [MAXW-1:0] b,
                                              input int unsigned     cw);
    logic [MAXW:0] sum;
    logic [MAXW:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((MAXW+1)'(1) << cw) - (MAXW+1)'(1);
    if (sum > lim) return lim[MAXW-1:0];
    return sum[MAXW-1:0];
  endfunction

  // Counts ones (val=1) or zeros (val=0) starting at the oldest sample.
  function automatic int unsigned cnt_trail(input logic [MAXW-1:0] w,
                                            input logic            val,
                                            input int unsigned     wid);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int k = 0; k < MAXW; k++) begin
      if (k < int'(wid) && run) begin
        if (w[k] == val) n++;
        else run = 1'b0;
      end
    end
    return n;
  endfunction

  // Counts ones (val=1) or zeros (val=0) starting at the newest sample.
  function automatic int unsigned cnt_lead(input logic [MAXW-1:0] w,
                                           input logic            val,
                                           input int unsigned     wid);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int k = MAXW-1; k >= 0; k--) begin
      if (k < int'(wid) && run) begin
        if (w[k] == val) n++;
        else run = 1'b0;
      end
    end
    return n;
  endfunction

  // Bit 0 is compared against prev; rise_only drops falling transitions.
  function automatic int unsigned edge_count(input logic [MAXW-1:0] w,
                                             input logic            prev,
                                             input logic            rise_only,
                                             input int unsigned     wid);
    int unsigned n;
    logic        p;
    n = 0;
    p = prev;
    for (int k = 0; k < MAXW; k++) begin
      if (k < int'(wid)) begin
        if ((w[k] != p) && (!rise_only || w[k])) n++;
        p = w[k];
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/sig_meter_ch.sv
// sig_meter_ch: one channel of the signal meter.
//   clk, rst_n      clock, synchronous active-low reset
//   smp[W]          sample word, bit 0 oldest
//   accept          word is valid this cycle; nothing changes otherwise
//   edge_mode       0 = both edges, 1 = rising only
//   clr             gate closes on this word; accumulators restart after it
//   freq_sum        edge accumulator including the current word
//   duty_sum        high-sample accumulator including the current word
//   t1, t0          last completed high / low run widths (registered)
module sig_meter_ch
  import sig_meter_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  smp,
  input  logic          accept,
  input  logic          edge_mode,
  input  logic          clr,
  output logic [CW-1:0] freq_sum,
  output logic [CW-1:0] duty_sum,
  output logic [CW-1:0] t1,
  output logic [CW-1:0] t0
);

  logic          prev_q;
  logic [CW-1:0] run_q;
  logic [CW-1:0] freq_q, duty_q, t1_q, t0_q;

  logic          lvl, seen;
  int            last;
  logic [CW-1:0] first_w, width_v, nt1, nt0, run_n;

  assign freq_sum = CW'(sat_add(MAXW'(freq_q),
                                MAXW'(edge_count(MAXW'(smp), prev_q, edge_mode, W)), CW));
  assign duty_sum = CW'(sat_add(MAXW'(duty_q), MAXW'($countones(smp)), CW));
  assign t1 = t1_q;
  assign t0 = t0_q;

  // Walk the word in sample order. The first edge closes the run carried in
  // from earlier words; later edges close runs that live inside this word.
  // Overwriting nt1/nt0 on every edge leaves the last completed run of each level.
  always_comb begin
    lvl     = prev_q;
    seen    = 1'b0;
    last    = 0;
    nt1     = t1_q;
    nt0     = t0_q;
    width_v = '0;
    first_w = CW'(sat_add(MAXW'(run_q), MAXW'(cnt_trail(MAXW'(smp), prev_q, W)), CW));
    for (int i = 0; i < W; i++) begin
      if (smp[i] != lvl) begin
        width_v = seen ? CW'(i - last) : first_w;
        if (lvl) nt1 = width_v;
        else     nt0 = width_v;
        seen = 1'b1;
        last = i;
        lvl  = smp[i];
      end
    end
    // An edge resets the carry to the trailing run; no edge extends the old one.
    run_n = seen ? CW'(cnt_lead(MAXW'(smp), smp[W-1], W))
                 : CW'(sat_add(MAXW'(run_q), MAXW'(W), CW));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      run_q  <= '0;
      freq_q <= '0;
      duty_q <= '0;
      t1_q   <= '0;
      t0_q   <= '0;
    end else if (accept) begin
      prev_q <= smp[W-1];
      run_q  <= run_n;
      t1_q   <= nt1;
      t0_q   <= nt0;
      freq_q <= clr ? '0 : freq_sum;
      duty_q <= clr ? '0 : duty_sum;
    end
  end

endmodule

// File: rtl/sig_meter_mc.sv
// sig_meter_mc: multi-channel pulse/frequency meter with gated results.
//   clk, rst_n      clock, synchronous active-low reset
//   smp[NCH*W]      sample words, channel c at [c*W +: W]
//   in_valid        qualifies smp
//   edge_mode[NCH]  per channel: 0 = both edges, 1 = rising only
//   res_valid       shadow bank holds unread results
//   res_ready       consumer acknowledge
//   overrun         sticky: a gate closed over unacknowledged results
//   rd_ch, rd_sel   read address (channel, field_e)
//   rd_data         registered shadow value, one cycle after the address
// NCH must be at least 2; W and CW at most 64.
module sig_meter_mc
  import sig_meter_pkg::*;
#(
  parameter int W    = 32,
  parameter int NCH  = 4,
  parameter int GATE = 31_250_000,
  parameter int CW   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*W-1:0]       smp,
  input  logic                   in_valid,
  input  logic [NCH-1:0]         edge_mode,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   overrun,
  input  logic [$clog2(NCH)-1:0] rd_ch,
  input  logic [1:0]             rd_sel,
  output logic [CW-1:0]          rd_data
);

  localparam int GW = $clog2(GATE + 1);

  logic [GW-1:0] g_q;
  logic          gate_close;
  logic [CW-1:0] ch_freq [NCH];
  logic [CW-1:0] ch_duty [NCH];
  logic [CW-1:0] ch_t1   [NCH];
  logic [CW-1:0] ch_t0   [NCH];
  logic [CW-1:0] sh_freq [NCH];
  logic [CW-1:0] sh_duty [NCH];
  logic [CW-1:0] sh_t1   [NCH];
  logic [CW-1:0] sh_t0   [NCH];
  logic [CW-1:0] rd_mux;

  assign gate_close = in_valid && (g_q == GW'(GATE - 1));

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sig_meter_ch #(.W(W), .CW(CW)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .smp      (smp[c*W +: W]),
      .accept   (in_valid),
      .edge_mode(edge_mode[c]),
      .clr      (gate_close),
      .freq_sum (ch_freq[c]),
      .duty_sum (ch_duty[c]),
      .t1       (ch_t1[c]),
      .t0       (ch_t0[c])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          g_q <= '0;
    else if (gate_close) g_q <= '0;
    else if (in_valid)   g_q <= g_q + GW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        sh_freq[c] <= '0;
        sh_duty[c] <= '0;
        sh_t1[c]   <= '0;
        sh_t0[c]   <= '0;
      end
    end else if (gate_close) begin
      for (int c = 0; c < NCH; c++) begin
        sh_freq[c] <= ch_freq[c];
        sh_duty[c] <= ch_duty[c];
        sh_t1[c]   <= ch_t1[c];
        sh_t0[c]   <= ch_t0[c];
      end
    end
  end

  // Handshake: results are transferred on any cycle with res_valid & res_ready;
  // res_valid drops the next cycle unless a gate closes in that same cycle,
  // in which case the new bank is offered immediately. A gate close that
  // finds res_valid set without an ack overwrites the bank and flags overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (gate_close) begin
      res_valid <= 1'b1;
      if (res_valid && !res_ready) overrun <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (int'(rd_ch) < NCH) begin
      case (field_e'(rd_sel))
        F_FREQ:  rd_mux = sh_freq[rd_ch];
        F_DUTY:  rd_mux = sh_duty[rd_ch];
        F_T1:    rd_mux = sh_t1[rd_ch];
        F_T0:    rd_mux = sh_t0[rd_ch];
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_sig_meter_mc.sv
// Directed bench for sig_meter_mc (W=8, NCH=2, GATE=4). A second instance with
// CW=8 shares every input and is used for the width-saturation case.
module tb_sig_meter_mc;

  logic        clk;
  logic        rst_n;
  logic [15:0] smp;
  logic        in_valid;
  logic [1:0]  edge_mode;
  logic        res_ready;
  logic        rd_ch;
  logic [1:0]  rd_sel;
  logic        res_valid, overrun;
  logic [31:0] rd_data;
  logic        res_valid8, overrun8;
  logic [7:0]  rd_data8;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  bit   [5:0]  pat = 6'b011001;  // in_valid for steps 0..5: 1,0,0,1,1,0

  sig_meter_mc #(.W(8), .NCH(2), .GATE(4), .CW(32)) dut (
    .clk(clk), .rst_n(rst_n), .smp(smp), .in_valid(in_valid),
    .edge_mode(edge_mode), .res_valid(res_valid), .res_ready(res_ready),
    .overrun(overrun), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data)
  );

  sig_meter_mc #(.W(8), .NCH(2), .GATE(4), .CW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .smp(smp), .in_valid(in_valid),
    .edge_mode(edge_mode), .res_valid(res_valid8), .res_ready(res_ready),
    .overrun(overrun8), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b1; smp = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drivers
  task automatic drive(input logic v, input logic [7:0] c0, input logic [7:0] c1);
    @(negedge clk);
    in_valid = v;
    smp      = {c1, c0};
  endtask

  task automatic idle();
    drive(1'b0, 8'h5A, 8'hC3);
  endtask

  task automatic rd(input logic ch, input logic [1:0] sel,
                    output logic [31:0] v, output logic [7:0] v8);
    @(negedge clk);
    in_valid = 1'b0;
    rd_ch    = ch;
    rd_sel   = sel;
    @(negedge clk);
    v  = rd_data;
    v8 = rd_data8;
  endtask

  // checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push4(input logic [31:0] f, input logic [31:0] d,
                       input logic [31:0] h, input logic [31:0] l);
    exp_q.push_back(f);
    exp_q.push_back(d);
    exp_q.push_back(h);
    exp_q.push_back(l);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, res_valid}, 32'd1);
  endtask

  // Pops four expected values (freq, duty, t1, t0) and reads them back.
  task automatic drain(input string tag, input logic ch, input logic narrow);
    logic [31:0] v, e;
    logic [7:0]  v8;
    for (int s = 0; s < 4; s++) begin
      rd(ch, 2'(s), v, v8);
      if (exp_q.size() == 0) begin
        chk($sformatf("%s_ch%0d_f%0d_queue", tag, ch, s), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_ch%0d_f%0d", tag, ch, s), narrow ? {24'b0, v8} : v, e);
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  v8;
    rst_n = 1'b0; in_valid = 1'b0; smp = '0; edge_mode = 2'b00;
    res_ready = 1'b1; rd_ch = 1'b0; rd_sel = 2'd0;

    // reset state
    do_reset();
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_overrun",   {31'b0, overrun},   32'd0);
    chk("rst_rd_data",   rd_data,            32'd0);

    // ch0 F0 (edges 1+2+2+2, high runs of 4), ch1 FF (one rise, zero-width low run)
    push4(32'd7, 32'd16, 32'd4, 32'd4);
    push4(32'd1, 32'd32, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hF0, 8'hFF);
    idle();
    wait_valid("g1_valid");
    drain("g1", 1'b0, 1'b0);
    drain("g1", 1'b1, 1'b0);

    // next gate: ch1 falls after 32 high samples; ch0 now 2 edges per word
    push4(32'd8, 32'd16, 32'd4, 32'd4);
    push4(32'd1, 32'd0, 32'd32, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hF0, 8'h00);
    idle();
    wait_valid("g2_valid");
    drain("g2", 1'b0, 1'b0);
    drain("g2", 1'b1, 1'b0);

    // reset clears shadow; ch0 rising-only
    do_reset();
    rd(1'b1, 2'd2, v, v8);
    chk("rst_shadow_t1", v, 32'd0);
    edge_mode = 2'b01;
    push4(32'd4, 32'd16, 32'd4, 32'd4);
    push4(32'd1, 32'd32, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hF0, 8'hFF);
    idle();
    wait_valid("rise_valid");
    drain("rise", 1'b0, 1'b0);
    drain("rise", 1'b1, 1'b0);
    edge_mode = 2'b00;

    // overrun: two gates without ack; bank must hold the second gate
    do_reset();
    res_ready = 1'b0;
    push4(32'd7, 32'd16, 32'd4, 32'd4);
    push4(32'd1, 32'd0, 32'd32, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hF0, 8'hFF);
    idle();
    chk("ovr_first_valid",   {31'b0, res_valid}, 32'd1);
    chk("ovr_first_overrun", {31'b0, overrun},   32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h0F, 8'h00);
    idle();
    chk("ovr_valid",   {31'b0, res_valid}, 32'd1);
    chk("ovr_overrun", {31'b0, overrun},   32'd1);
    drain("ovr", 1'b0, 1'b0);
    drain("ovr", 1'b1, 1'b0);
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("ovr_ack_valid",   {31'b0, res_valid}, 32'd0);
    chk("ovr_ack_sticky",  {31'b0, overrun},   32'd1);
    res_ready = 1'b1;

    // gaps in in_valid: only accepted 0F words count (first word rises from prev 0)
    do_reset();
    push4(32'd8, 32'd16, 32'd4, 32'd4);
    push4(32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++)
      drive(pat[i], pat[i] ? 8'h0F : 8'hA5, pat[i] ? 8'h00 : 8'h3C);
    idle();
    chk("gap_no_early_valid", {31'b0, res_valid}, 32'd0);
    drive(1'b1, 8'h0F, 8'h00);
    idle();
    wait_valid("gap_valid");
    drain("gap", 1'b0, 1'b0);
    drain("gap", 1'b1, 1'b0);

    // width saturation: 320 high samples then a fall; CW=8 clamps at 255
    do_reset();
    push4(32'd1, 32'd0, 32'd255, 32'd0);
    push4(32'd1, 32'd0, 32'd320, 32'd0);
    for (int i = 0; i < 40; i++) drive(1'b1, 8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++)  drive(1'b1, 8'h00, 8'h00);
    idle();
    drain("sat8", 1'b0, 1'b1);
    drain("sat32", 1'b0, 1'b0);

    // reset two words into a gate; AA: 7 edges then 8 per word, unit runs
    do_reset();
    for (int i = 0; i < 2; i++) drive(1'b1, 8'hFF, 8'hFF);
    do_reset();
    push4(32'd31, 32'd16, 32'd1, 32'd1);
    push4(32'd31, 32'd16, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hAA, 8'hAA);
    idle();
    chk("mid_rst_no_early", {31'b0, res_valid}, 32'd0);
    drive(1'b1, 8'hAA, 8'hAA);
    idle();
    wait_valid("mid_rst_valid");
    chk("mid_rst_overrun", {31'b0, overrun}, 32'd0);
    drain("mid_rst", 1'b0, 1'b0);
    drain("mid_rst", 1'b1, 1'b0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
